// File: rtl/window_packer_27.sv
// -----------------------------------------------------------------------------
// window_packer_27
//
// Collects a stream of signed elements into fixed-size windows of NUM_INPUTS
// elements and presents each complete window as one packed word.
//
// One window can wait in the output register while the next is collected.
// A second complete window can be parked in the fill buffer. In that case
// collection stalls until the output register is consumed.
//
// Ports
//   clk            rising-edge clock for all state
//   rst            asynchronous active-low reset
//   in_data        signed element, stream order
//   in_valid       in_data / in_last qualify
//   in_last        marks the final element of a window
//   in_ready       element accepted this cycle when in_valid is also high
//   input_numbers  packed window, element k at [k*bitsize +: bitsize]
//   data_valid     input_numbers holds an unconsumed window
//   out_ready      downstream consumes the window this cycle
//   count          elements collected in the current partial window
//   frame_err      sticky framing-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module window_packer_27 #(
   parameter int bitsize    = 14,
   parameter int NUM_INPUTS = 27
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic signed [bitsize-1:0]        in_data,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [NUM_INPUTS*bitsize-1:0]    input_numbers,
   output logic                             data_valid,
   input  logic                             out_ready,
   output logic [4:0]                       count,
   output logic                             frame_err
);

   localparam int         WIN_W = NUM_INPUTS * bitsize;
   localparam logic [4:0] LAST  = 5'(NUM_INPUTS - 1);

   logic [WIN_W-1:0] fill_q, fill_d;
   logic [WIN_W-1:0] out_q, out_d;
   logic [4:0]       count_q, count_d;
   logic             dv_q, dv_d;
   logic             full_q, full_d;
   logic             ferr_q, ferr_d;

   logic accept;
   logic consume;
   logic out_free;
   logic load;

   assign accept   = in_valid & ~full_q;
   assign consume  = dv_q & out_ready;
   assign out_free = ~dv_q | out_ready;

   always_comb begin
      fill_d  = fill_q;
      out_d   = out_q;
      count_d = count_q;
      dv_d    = dv_q;
      full_d  = full_q;
      ferr_d  = ferr_q;
      load    = 1'b0;

      if (accept) begin
         fill_d[int'(count_q)*bitsize +: bitsize] = in_data;
      end

      if (full_q) begin
         // A parked window moves out as soon as the output register is consumed.
         // data_valid is already 1 here, so it simply stays 1.
         if (consume) begin
            out_d   = fill_q;
            full_d  = 1'b0;
            count_d = '0;
            load    = 1'b1;
         end
      end else if (accept) begin
         if (count_q == LAST) begin
            if (!in_last) begin
               ferr_d = 1'b1;
            end
            if (out_free) begin
               // fill_d already includes the element arriving this cycle.
               out_d   = fill_d;
               dv_d    = 1'b1;
               count_d = '0;
               load    = 1'b1;
            end else begin
               // Park the window; count stays at LAST while stalled.
               full_d = 1'b1;
            end
         end else if (in_last) begin
            // Early in_last: drop the partial window and resynchronise.
            ferr_d  = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + 5'd1;
         end
      end

      if (consume && !load) begin
         dv_d = 1'b0;
      end
   end

   // The fill buffer needs no reset: count restarts at slot 0 and every slot
   // is rewritten before a window can be emitted.
   always_ff @(posedge clk) begin
      fill_q <= fill_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         count_q <= '0;
         dv_q    <= 1'b0;
         full_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         out_q   <= out_d;
         count_q <= count_d;
         dv_q    <= dv_d;
         full_q  <= full_d;
         ferr_q  <= ferr_d;
      end
   end

   assign in_ready      = ~full_q;
   assign input_numbers = out_q;
   assign data_valid    = dv_q;
   assign count         = count_q;
   assign frame_err     = ferr_q;

endmodule

// File: tb/tb_window_packer_27.sv
// -----------------------------------------------------------------------------
// tb_window_packer_27
//
// Directed stimulus for window_packer_27. A queue-based window model tracks
// the expected outputs and is compared against the DUT on every cycle.
// Hand-computed literals (window sums, slot bit patterns, flags) pin the
// model at key points.
// -----------------------------------------------------------------------------
module tb_window_packer_27;

   localparam int W = 14;
   localparam int N = 27;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic signed [W-1:0]   in_data = '0;
   logic                  in_valid = 1'b0;
   logic                  in_last = 1'b0;
   logic                  out_ready = 1'b0;
   logic                  in_ready;
   logic [N*W-1:0]        input_numbers;
   logic                  data_valid;
   logic [4:0]            count;
   logic                  frame_err;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   window_packer_27 #(.bitsize(W), .NUM_INPUTS(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .input_numbers (input_numbers),
      .data_valid    (data_valid),
      .out_ready     (out_ready),
      .count         (count),
      .frame_err     (frame_err)
   );

   // ---------------- behavioural model ----------------
   logic [W-1:0]   m_part[$];
   logic [N*W-1:0] m_out  = '0;
   logic [N*W-1:0] m_held = '0;
   logic [N*W-1:0] m_w;
   bit             m_dv   = 1'b0;
   bit             m_full = 1'b0;
   bit             m_ferr = 1'b0;
   bit             m_moved;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_part.delete();
         m_out  = '0;
         m_held = '0;
         m_dv   = 1'b0;
         m_full = 1'b0;
         m_ferr = 1'b0;
      end else begin
         m_moved = 1'b0;
         if (m_full) begin
            if (out_ready) begin
               m_out   = m_held;
               m_full  = 1'b0;
               m_moved = 1'b1;
            end
         end else if (in_valid) begin
            m_part.push_back(in_data);
            if (m_part.size() == N) begin
               if (!in_last) m_ferr = 1'b1;
               m_w = '0;
               foreach (m_part[k]) m_w[k*W +: W] = m_part[k];
               m_part.delete();
               if (!m_dv || out_ready) begin
                  m_out   = m_w;
                  m_dv    = 1'b1;
                  m_moved = 1'b1;
               end else begin
                  m_held = m_w;
                  m_full = 1'b1;
               end
            end else if (in_last) begin
               m_ferr = 1'b1;
               m_part.delete();
            end
         end
         if (m_dv && out_ready && !m_moved) m_dv = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int wsum(input logic [N*W-1:0] w);
      int s = 0;
      for (int k = 0; k < N; k++) s += int'($signed(w[k*W +: W]));
      return s;
   endfunction

   function automatic logic [W-1:0] slot(input logic [N*W-1:0] w, input int k);
      return w[k*W +: W];
   endfunction

   // Presents one element from a falling edge and returns on the falling edge
   // after it was accepted.
   task automatic send(input int v, input bit last);
      int g = 0;
      in_valid = 1'b1;
      in_data  = W'(v);
      in_last  = last;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) begin
         nvec++;
         nerr++;
         $display("FAIL send_stall: in_ready stuck at 0 for %0d cycles", g);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("in_ready",      in_ready,      !m_full);
         chk("data_valid",    data_valid,    m_dv);
         chk("count",         count,         m_full ? N-1 : m_part.size());
         chk("frame_err",     frame_err,     m_ferr);
         chk("input_numbers", input_numbers, m_out);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_input_numbers", input_numbers, '0);
      chk("rst_data_valid",    data_valid,    1'b0);
      chk("rst_count",         count,         5'd0);
      chk("rst_in_ready",      in_ready,      1'b1);
      chk("rst_frame_err",     frame_err,     1'b0);
      rst    = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // Basic window 1..27 with downstream ready.
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         send(k + 1, k == N-1);
         if (k == N-2) chk("dv_before_last", data_valid, 1'b0);
      end
      chk("w1_valid", data_valid, 1'b1);
      chki("w1_sum", wsum(input_numbers), 378);
      chk("w1_slot0", slot(input_numbers, 0), 14'd1);
      chk("w1_slot26", slot(input_numbers, 26), 14'd27);
      repeat (2) @(negedge clk);

      // Backpressure: two windows while out_ready=0, second parks.
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) send(k + 1, k == N-1);
      for (int k = 0; k < N; k++) send(-2 * (k + 1), k == N-1);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_count_held", count, 5'd26);
      chki("bp_first_sum", wsum(input_numbers), 378);
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_valid", data_valid, 1'b1);
      chki("bp_second_sum", wsum(input_numbers), -756);
      chk("bp_slot0", slot(input_numbers, 0), 14'h3FFE);
      chk("bp_in_ready_back", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Early in_last on the 10th element.
      for (int k = 0; k < 10; k++) send(k + 1, k == 9);
      chk("fe_flag", frame_err, 1'b1);
      chk("fe_count", count, 5'd0);
      chk("fe_no_valid", data_valid, 1'b0);
      for (int k = 0; k < N; k++) send(100 + k, k == N-1);
      chki("fe_recover_sum", wsum(input_numbers), 100*N + 351);
      chk("fe_sticky", frame_err, 1'b1);
      repeat (2) @(negedge clk);

      // Reset in the middle of a window.
      for (int k = 0; k < 13; k++) send(7, 1'b0);
      rst = 1'b0;
      #1;
      chk("mid_rst_count", count, 5'd0);
      chk("mid_rst_valid", data_valid, 1'b0);
      chk("mid_rst_ferr", frame_err, 1'b0);
      chk("mid_rst_data", input_numbers, '0);
      chk("mid_rst_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) send(5, k == N-1);
      chk("post_rst_valid", data_valid, 1'b1);
      chki("post_rst_sum", wsum(input_numbers), 135);
      repeat (2) @(negedge clk);

      // Consume and complete on the same cycle.
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) send(k + 1, k == N-1);
      for (int k = 0; k < N-1; k++) send(3, 1'b0);
      out_ready = 1'b1;
      send(4, 1'b1);
      chk("same_cyc_valid", data_valid, 1'b1);
      chki("same_cyc_sum", wsum(input_numbers), 82);
      chk("same_cyc_slot26", slot(input_numbers, 26), 14'd4);
      chk("same_cyc_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);

      // Extreme values, streamed back to back; second window lacks in_last.
      for (int i = 0; i < 2*N; i++) begin
         send((i % 2) ? 8191 : -8192, i == N-1);
         if (i == N-1) begin
            chk("ext_slot0", slot(input_numbers, 0), 14'h2000);
            chk("ext_slot1", slot(input_numbers, 1), 14'h1FFF);
            chk("ext_ferr_clear", frame_err, 1'b0);
         end
      end
      chk("ext_w2_valid", data_valid, 1'b1);
      chk("ext_w2_slot0", slot(input_numbers, 0), 14'h1FFF);
      chk("ext_missing_last", frame_err, 1'b1);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
